// File: rtl/main_mem_arbiter.sv
// main_mem_arbiter: shares main_mem's single data port between the core LSU
// (requester 0) and the loader/debug DMA (requester 1). It also sequences
// fence_i so the fence never overlaps data reads that are still in flight.
// The grant is combinational and is issued in the cycle the request is seen.
// Read data comes back RD_LAT cycles after the grant. It is steered to the
// requester that issued the read by a small {valid, src} tag pipeline.
module main_mem_arbiter #(
  parameter int AW     = 14,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  // requester 0: core load/store unit
  input  logic          i_r0_req,
  input  logic          i_r0_wen,
  input  logic [3:0]    i_r0_ben,
  input  logic [AW-1:0] i_r0_addr,
  input  logic [DW-1:0] i_r0_wdata,
  output logic          o_r0_gnt,
  output logic          o_r0_rvalid,
  output logic [DW-1:0] o_r0_rdata,
  // requester 1: loader / debug DMA
  input  logic          i_r1_req,
  input  logic          i_r1_wen,
  input  logic [3:0]    i_r1_ben,
  input  logic [AW-1:0] i_r1_addr,
  input  logic [DW-1:0] i_r1_wdata,
  output logic          o_r1_gnt,
  output logic          o_r1_rvalid,
  output logic [DW-1:0] o_r1_rdata,
  // instruction-fetch coherence
  input  logic          i_fence_req,
  output logic          o_fence_done,
  // main_mem data port
  output logic          o_dm_ren,
  output logic          o_dm_wen,
  output logic [3:0]    o_dm_ben,
  output logic [AW-1:0] o_dm_addr,
  output logic [DW-1:0] o_dm_wdata,
  input  logic [DW-1:0] i_dm_rdata,
  output logic          o_fence_i,
  input  logic          i_mem_ready
);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FENCE = 2'd2,
    ST_FWAIT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                rr_q, rr_d;          // 0: r0 wins a tie, 1: r1 wins a tie
  logic                blk_q, blk_d;        // outputs forced low the cycle after reset
  logic [RD_LAT-1:0]   tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0]   tag_src_q, tag_src_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [DW-1:0]       wdata_q, wdata_d;

  logic                out_blk;
  logic                can_grant;
  logic                gnt_vld;
  logic                sel;                 // granted requester index
  logic                sel_wen;
  logic [3:0]          sel_ben;
  logic [AW-1:0]       sel_addr;
  logic [DW-1:0]       sel_wdata;
  logic                rd_vld;
  logic                rd_src;

  // Every output is held low while reset is asserted and for one cycle afterwards.
  assign out_blk = i_rst | blk_q;

  // Pick at most one requester per cycle and mux its fields.
  always_comb begin
    can_grant = 1'b0;
    gnt_vld   = 1'b0;
    sel       = 1'b0;
    sel_wen   = 1'b0;
    sel_ben   = 4'h0;
    sel_addr  = '0;
    sel_wdata = '0;
    // A fence request in ARB has priority over any request in the same cycle.
    can_grant = (state_q == ST_ARB) && !i_fence_req && i_mem_ready && !out_blk;
    if (i_r0_req && i_r1_req) begin
      sel = rr_q;
    end else begin
      sel = i_r1_req;
    end
    gnt_vld = can_grant && (i_r0_req || i_r1_req);
    if (sel) begin
      sel_wen   = i_r1_wen;
      sel_ben   = i_r1_ben;
      sel_addr  = i_r1_addr;
      sel_wdata = i_r1_wdata;
    end else begin
      sel_wen   = i_r0_wen;
      sel_ben   = i_r0_ben;
      sel_addr  = i_r0_addr;
      sel_wdata = i_r0_wdata;
    end
  end

  // Fence sequencer: wait for in-flight reads, pulse fence_i, then wait for ready.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ARB: begin
        if (i_fence_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((tag_vld_q == '0) && i_mem_ready) state_d = ST_FENCE;
      end
      ST_FENCE: begin
        state_d = ST_FWAIT;
      end
      ST_FWAIT: begin
        if (i_mem_ready) state_d = ST_ARB;
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  // Round-robin pointer moves to the other requester after every grant.
  // The post-reset output block releases after one cycle.
  always_comb begin
    rr_d  = rr_q;
    blk_d = 1'b0;
    if (gnt_vld) rr_d = ~sel;
  end

  // Read-tag pipeline: one {valid, src} entry per cycle, reads only mark valid.
  always_comb begin
    tag_vld_d    = '0;
    tag_src_d    = '0;
    tag_vld_d[0] = gnt_vld & ~sel_wen;
    tag_src_d[0] = sel;
    for (int k = 1; k < RD_LAT; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_src_d[k] = tag_src_q[k-1];
    end
  end

  // Address and write data keep their last granted value between grants.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (gnt_vld) begin
      addr_d  = sel_addr;
      wdata_d = sel_wdata;
    end
  end

  // Control and output-hold state, with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_ARB;
      rr_q      <= 1'b0;
      blk_q     <= 1'b1;
      tag_vld_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      blk_q     <= blk_d;
      tag_vld_q <= tag_vld_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  // Tag source bits are only meaningful alongside a set valid bit, so no reset.
  always_ff @(posedge i_clk) begin
    tag_src_q <= tag_src_d;
  end

  // ---- read return: output end of the tag pipeline ----
  assign rd_vld = tag_vld_q[RD_LAT-1] & ~out_blk;
  assign rd_src = tag_src_q[RD_LAT-1];

  assign o_r0_rvalid = rd_vld & ~rd_src;
  assign o_r1_rvalid = rd_vld &  rd_src;
  assign o_r0_rdata  = o_r0_rvalid ? i_dm_rdata : '0;
  assign o_r1_rdata  = o_r1_rvalid ? i_dm_rdata : '0;

  assign o_r0_gnt    = gnt_vld & ~sel;
  assign o_r1_gnt    = gnt_vld &  sel;

  assign o_dm_ren    = gnt_vld & ~sel_wen;
  assign o_dm_wen    = gnt_vld &  sel_wen;
  assign o_dm_ben    = gnt_vld ? sel_ben : 4'h0;
  assign o_dm_addr   = out_blk ? '0 : (gnt_vld ? sel_addr  : addr_q);
  assign o_dm_wdata  = out_blk ? '0 : (gnt_vld ? sel_wdata : wdata_q);

  assign o_fence_i    = (state_q == ST_FENCE) & ~out_blk;
  assign o_fence_done = (state_q == ST_FWAIT) & i_mem_ready & ~out_blk;

endmodule
